// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types, result codes and legality check for the comparator result tracker
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  // Result codes are ordered {ceq, clt, cgt}
  localparam logic [2:0] CODE_EQ = 3'b100;
  localparam logic [2:0] CODE_LT = 3'b010;
  localparam logic [2:0] CODE_GT = 3'b001;

  function automatic logic is_one_hot(input logic [2:0] code);
    return (code == CODE_EQ) || (code == CODE_LT) || (code == CODE_GT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - unsigned up-counter with synchronous clear that holds at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cmp_result_tracker.sv
// rtl/cmp_result_tracker.sv - counts comparator outcomes, detects equal runs and flags illegal codes
module cmp_result_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int STREAK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             ceq,
  input  logic             clt,
  input  logic             cgt,
  input  logic             clear,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             streak_hit,
  output logic             err_code,
  output logic             active
);

  localparam logic [7:0] STREAK_MAX = 8'(STREAK_LEN);

  logic [2:0] code;
  logic       legal;
  logic       illegal;
  logic [7:0] streak_cnt;
  logic [7:0] streak_next;
  logic       hit_now;
  state_t     state;
  state_t     state_next;

  assign code    = {ceq, clt, cgt};
  assign legal   = in_valid && is_one_hot(code);
  assign illegal = in_valid && !is_one_hot(code);

  sat_counter #(.W(CNT_W)) u_eq_cnt (.clk(clk), .rst_n(rst_n), .clr(clear), .inc(legal && ceq), .cnt(eq_cnt));
  sat_counter #(.W(CNT_W)) u_lt_cnt (.clk(clk), .rst_n(rst_n), .clr(clear), .inc(legal && clt), .cnt(lt_cnt));
  sat_counter #(.W(CNT_W)) u_gt_cnt (.clk(clk), .rst_n(rst_n), .clr(clear), .inc(legal && cgt), .cnt(gt_cnt));
  sat_counter #(.W(CNT_W)) u_sample_cnt (.clk(clk), .rst_n(rst_n), .clr(clear), .inc(legal), .cnt(sample_cnt));

  // Only legal samples move the run length; gaps and illegal codes leave it alone
  always_comb begin
    streak_next = streak_cnt;
    if (legal) begin
      if (ceq) begin
        streak_next = (streak_cnt >= STREAK_MAX) ? STREAK_MAX : streak_cnt + 8'd1;
      end else begin
        streak_next = 8'd0;
      end
    end
  end

  assign hit_now = legal && ceq && (streak_next == STREAK_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_cnt <= 8'd0;
      streak_hit <= 1'b0;
      err_code   <= 1'b0;
    end else if (clear) begin
      streak_cnt <= 8'd0;
      streak_hit <= 1'b0;
      err_code   <= 1'b0;
    end else begin
      streak_cnt <= streak_next;
      if (hit_now) streak_hit <= 1'b1;
      if (illegal) err_code <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (legal) state_next = hit_now ? LOCK : TRACK;
        TRACK:   if (hit_now) state_next = LOCK;
        LOCK:    state_next = LOCK;
        default: state_next = IDLE;
      endcase
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_cmp_result_tracker.sv
// tb/tb_cmp_result_tracker.sv - directed table-driven bench for cmp_result_tracker
module tb_cmp_result_tracker;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       ceq = 1'b0;
  logic       clt = 1'b0;
  logic       cgt = 1'b0;
  logic       clear = 1'b0;

  logic [7:0] eq_cnt, lt_cnt, gt_cnt, sample_cnt;
  logic       streak_hit, err_code, active;
  logic [3:0] eq_cnt4, lt_cnt4, gt_cnt4, sample_cnt4;
  logic       streak_hit4, err_code4, active4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cmp_result_tracker #(.CNT_W(8), .STREAK_LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ceq(ceq), .clt(clt), .cgt(cgt),
    .clear(clear), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .gt_cnt(gt_cnt),
    .sample_cnt(sample_cnt), .streak_hit(streak_hit), .err_code(err_code), .active(active)
  );

  cmp_result_tracker #(.CNT_W(4), .STREAK_LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ceq(ceq), .clt(clt), .cgt(cgt),
    .clear(clear), .eq_cnt(eq_cnt4), .lt_cnt(lt_cnt4), .gt_cnt(gt_cnt4),
    .sample_cnt(sample_cnt4), .streak_hit(streak_hit4), .err_code(err_code4), .active(active4)
  );

  typedef struct {
    logic       clr;
    logic       vld;
    logic [2:0] code;
    logic [7:0] e, l, g, s;
    logic       h, er, a;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [7:0] e, input logic [7:0] l,
                       input logic [7:0] g, input logic [7:0] s,
                       input logic h, input logic er, input logic a);
    logic [34:0] act_v, exp_v;
    act_v = {eq_cnt, lt_cnt, gt_cnt, sample_cnt, streak_hit, err_code, active};
    exp_v = {e, l, g, s, h, er, a};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got eq=%0d lt=%0d gt=%0d smp=%0d hit=%b err=%b act=%b, want eq=%0d lt=%0d gt=%0d smp=%0d hit=%b err=%b act=%b",
               name, eq_cnt, lt_cnt, gt_cnt, sample_cnt, streak_hit, err_code, active,
               e, l, g, s, h, er, a);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] e, input logic [3:0] l,
                        input logic [3:0] g, input logic [3:0] s);
    vectors++;
    if ({eq_cnt4, lt_cnt4, gt_cnt4, sample_cnt4} !== {e, l, g, s}) begin
      miscompares++;
      $display("FAIL %s: got eq=%0d lt=%0d gt=%0d smp=%0d, want eq=%0d lt=%0d gt=%0d smp=%0d",
               name, eq_cnt4, lt_cnt4, gt_cnt4, sample_cnt4, e, l, g, s);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge capture, return at the next falling edge
  task automatic apply(input logic clr, input logic vld, input logic [2:0] code);
    clear    = clr;
    in_valid = vld;
    {ceq, clt, cgt} = code;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    {ceq, clt, cgt} = 3'b000;
  endtask

  initial begin
    // mixed counting
    tbl.push_back('{0, 1, EQ,     1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{0, 1, LT,     1, 1, 0, 2, 0, 0, 1});
    tbl.push_back('{0, 1, GT,     1, 1, 1, 3, 0, 0, 1});
    tbl.push_back('{0, 1, EQ,     2, 1, 1, 4, 0, 0, 1});
    tbl.push_back('{0, 1, GT,     2, 1, 2, 5, 0, 0, 1});
    tbl.push_back('{0, 1, GT,     2, 1, 3, 6, 0, 0, 1});
    tbl.push_back('{1, 1, EQ,     0, 0, 0, 0, 0, 0, 0});
    // streak with gaps
    tbl.push_back('{0, 1, EQ,     1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{0, 1, EQ,     2, 0, 0, 2, 0, 0, 1});
    tbl.push_back('{0, 0, 3'b111, 2, 0, 0, 2, 0, 0, 1});
    tbl.push_back('{0, 0, 3'b000, 2, 0, 0, 2, 0, 0, 1});
    tbl.push_back('{0, 1, EQ,     3, 0, 0, 3, 0, 0, 1});
    tbl.push_back('{0, 1, EQ,     4, 0, 0, 4, 1, 0, 1});
    tbl.push_back('{0, 1, LT,     4, 1, 0, 5, 1, 0, 1});
    tbl.push_back('{1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0});
    // broken run
    tbl.push_back('{0, 1, EQ,     1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{0, 1, EQ,     2, 0, 0, 2, 0, 0, 1});
    tbl.push_back('{0, 1, EQ,     3, 0, 0, 3, 0, 0, 1});
    tbl.push_back('{0, 1, LT,     3, 1, 0, 4, 0, 0, 1});
    tbl.push_back('{0, 1, EQ,     4, 1, 0, 5, 0, 0, 1});
    tbl.push_back('{0, 1, EQ,     5, 1, 0, 6, 0, 0, 1});
    tbl.push_back('{0, 1, EQ,     6, 1, 0, 7, 0, 0, 1});
    tbl.push_back('{1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0});
    // illegal codes, then a run interleaved with illegal codes
    tbl.push_back('{0, 1, 3'b000, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 3'b110, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 1, EQ,     1, 0, 0, 1, 0, 1, 1});
    tbl.push_back('{0, 1, EQ,     2, 0, 0, 2, 0, 1, 1});
    tbl.push_back('{0, 1, 3'b111, 2, 0, 0, 2, 0, 1, 1});
    tbl.push_back('{0, 1, EQ,     3, 0, 0, 3, 0, 1, 1});
    tbl.push_back('{0, 1, 3'b011, 3, 0, 0, 3, 0, 1, 1});
    tbl.push_back('{0, 1, EQ,     4, 0, 0, 4, 1, 1, 1});
    // clear beats a legal sample while locked with err set
    tbl.push_back('{1, 1, EQ,     0, 0, 0, 0, 0, 0, 0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset", 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].clr, tbl[i].vld, tbl[i].code);
      check($sformatf("vec%0d", i), tbl[i].e, tbl[i].l, tbl[i].g, tbl[i].s,
            tbl[i].h, tbl[i].er, tbl[i].a);
    end

    for (int i = 0; i < 20; i++) apply(0, 1, GT);
    check4("sat4_gt", 0, 0, 15, 15);
    check("sat8_gt", 0, 0, 20, 20, 0, 0, 1);
    apply(0, 1, GT);
    check4("sat4_hold", 0, 0, 15, 15);

    apply(1, 0, 3'b000);
    for (int i = 0; i < 5; i++) apply(0, 1, EQ);
    check("pre_async", 5, 0, 0, 5, 1, 0, 1);
    #1 rst_n = 1'b0;
    #1 check("async_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 1, LT);
    check("post_reset_lt", 0, 1, 0, 1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmp_result_tracker.md
Name: cmp_result_tracker

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Consumes its one-hot result triplet (ceq/clt/cgt) under a sample strobe.
- Keeps saturating per-outcome counts and a total-sample count, and detects a run of consecutive "equal" results.
- Flags illegal (non-one-hot) result codes for the control/status logic above it.

Parameters:
- CNT_W, 8: width of every counter; counters saturate at 2^CNT_W-1.
- STREAK_LEN, 4: number of consecutive valid "equal" samples that asserts streak_hit; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample strobe; ceq/clt/cgt are consumed when high.
- ceq  input  1  comparator result a==b.
- clt  input  1  comparator result a<b.
- cgt  input  1  comparator result a>b.
- clear  input  1  synchronous clear of all counters, flags and FSM.
- eq_cnt  output  CNT_W  count of legal samples with ceq.
- lt_cnt  output  CNT_W  count of legal samples with clt.
- gt_cnt  output  CNT_W  count of legal samples with cgt.
- sample_cnt  output  CNT_W  count of legal samples.
- streak_hit  output  1  equal-run threshold reached; sticky.
- err_code  output  1  sticky: a non-one-hot code was seen with in_valid=1.
- active  output  1  high when FSM is not IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). Reset asynchronously forces every output to 0, FSM to IDLE and the internal streak counter to 0.
- All outputs are registered. A sample taken on edge N is reflected on the outputs after edge N; latency is 1 cycle. No combinational path runs from inputs to outputs.
- Legal sample: in_valid=1 and exactly one of {ceq,clt,cgt} is 1.
- Illegal sample: in_valid=1 and zero, two or three of the bits are 1.
- Legal sample handling:
  - sample_cnt increments, plus the matching outcome counter.
  - Each counter saturates independently: at all-ones it holds and never wraps.
- Illegal sample handling:
  - err_code sets and stays set until clear or reset.
  - No counter changes. The streak counter is unchanged. The FSM does not move.
- in_valid=0: ceq/clt/cgt are don't-care. Nothing changes; gaps do not break a streak.
- Streak counter: internal 8-bit.
  - Legal ceq increments it, saturating at STREAK_LEN.
  - Legal clt or cgt resets it to 0.
  - On the edge where the next value reaches STREAK_LEN, streak_hit sets, so it is visible 1 cycle after the STREAK_LEN-th equal sample.
- FSM states: IDLE, TRACK, LOCK.
  - IDLE -> TRACK on the first legal sample. If STREAK_LEN=1 and that sample is ceq, go IDLE -> LOCK directly.
  - TRACK -> LOCK when streak_hit sets.
  - LOCK holds until clear or reset. Counters keep counting in LOCK; streak_hit stays 1 even if non-equal samples follow.
  - active = (state != IDLE).
- clear=1 at an edge:
  - Zeros all counters, the streak counter, streak_hit and err_code; FSM -> IDLE.
  - Takes priority over a simultaneous sample, which is discarded (legal or illegal).
- Reset mid-operation: immediate asynchronous return to the reset state. After release the first edge behaves as from IDLE.
- Width rules: all counters are CNT_W bits unsigned. No arithmetic crosses widths.

Decomposition:
- Shared package cmp_pkg holds:
  - the FSM state typedef (IDLE=2'd0, TRACK=2'd1, LOCK=2'd2);
  - one-hot code constants CODE_EQ=3'b100, CODE_LT=3'b010, CODE_GT=3'b001, ordered {ceq,clt,cgt};
  - a function that checks legal one-hot encoding.
- One sub-module, sat_counter: CNT_W-wide, with inc, clr and saturate-at-max; instantiated four times.
- Streak counter and FSM stay in the top module.

Test Plan:
- Reset/defaults: hold rst_n=0 for 3 cycles, release -> all outputs 0, active=0. Assert rst_n=0 asynchronously mid-cycle after 5 samples -> outputs 0 before the next edge.
- Mixed counting: 6 legal samples eq,lt,gt,eq,gt,gt with in_valid=1 -> eq_cnt=2, lt_cnt=1, gt_cnt=3, sample_cnt=6, active=1 after the first sample, streak_hit=0.
- Streak with gaps (STREAK_LEN=4): eq,eq,(in_valid=0 x2),eq,eq -> streak_hit rises exactly 1 cycle after the 4th eq, FSM in LOCK. A following lt keeps streak_hit=1. The sequence eq,eq,eq,lt,eq,eq,eq -> streak_hit stays 0.
- Illegal codes: in_valid=1 with {ceq,clt,cgt}=3'b000, then 3'b110 -> err_code=1, all counters unchanged, FSM stays IDLE. An interleaved eq streak is not broken by the illegal samples.
- Saturation (CNT_W=4): 20 legal gt samples -> gt_cnt=15 and sample_cnt=15, held with no wrap; eq_cnt=lt_cnt=0.
- Clear priority: clear=1 together with a legal eq while in LOCK with err_code=1 -> next cycle all counters 0, streak_hit=0, err_code=0, active=0. The discarded sample is not counted.
